usb_rx_phy: RTL



---
 rtl/usb_rx_phy.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_rx_phy.sv
// USB receive front end: pin synchroniser, 4-phase DPLL, NRZI decode, bit unstuffing, SYNC/EOP detection.
// Optional macro USB_RX_GLITCH_FILTER_EN inserts a 2-clock agreement filter ahead of line_state.
module usb_rx_phy #(
  parameter int FULL_SPEED     = 1,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_p,
  input  logic       d_n,
  output logic [1:0] line_state,
  output logic       rx_active,
  output logic       rx_sop,
  output logic       rx_valid,
  output logic       rx_data,
  output logic       rx_eop,
  output logic       rx_error
);

  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [1:0] LS_SE1 = 2'd3;

  localparam logic J_DP = (FULL_SPEED != 0) ? 1'b1 : 1'b0;
  localparam logic J_DN = ~J_DP;

  localparam logic [3:0] MIN_ZEROS = 4'(SYNC_MIN_ZEROS);
  localparam logic [2:0] ONES_STUFF = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP   = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  function automatic logic [1:0] decode_pins(input logic dp, input logic dn);
    logic [1:0] ls;
    case ({dp, dn})
      2'b00:   ls = LS_SE0;
      2'b11:   ls = LS_SE1;
      default: ls = (dp == J_DP) ? LS_J : LS_K;
    endcase
    return ls;
  endfunction

  logic       dp_s1_r;
  logic       dn_s1_r;
  logic [1:0] sym_s1_s;
  logic [1:0] line_next_s;
  logic [1:0] phase_r;
  logic       strobe_s;

  assign sym_s1_s = decode_pins(dp_s1_r, dn_s1_r);

`ifdef USB_RX_GLITCH_FILTER_EN
  logic [1:0] sym_s2_r;

  // Second synchroniser stage, held apart from line_state so the filter can compare two samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_s2_r <= LS_J;
    end else begin
      sym_s2_r <= sym_s1_s;
    end
  end

  // Accept a new symbol only once both stages agree on it
  always_comb begin
    line_next_s = line_state;
    if (sym_s1_s == sym_s2_r) begin
      line_next_s = sym_s2_r;
    end else begin
      line_next_s = line_state;
    end
  end
`else
  // Without the filter the second stage is line_state itself
  always_comb begin
    line_next_s = sym_s1_s;
  end
`endif

  // Pin synchroniser and DPLL phase; phase is 0 in the first cycle a new symbol is visible
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_s1_r    <= J_DP;
      dn_s1_r    <= J_DN;
      line_state <= LS_J;
      phase_r    <= 2'd0;
    end else begin
      dp_s1_r    <= d_p;
      dn_s1_r    <= d_n;
      line_state <= line_next_s;
      if (line_next_s != line_state) begin
        phase_r <= 2'd0;
      end else begin
        phase_r <= phase_r + 2'd1;
      end
    end
  end

  assign strobe_s = (phase_r == 2'd2);

  state_t     state_r;
  logic [1:0] prev_sym_r;
  logic [2:0] zero_cnt_r;
  logic [2:0] ones_cnt_r;
  logic [1:0] se0_cnt_r;
  logic       bit_s;

  assign bit_s = (line_state == prev_sym_r);

  // Receive FSM; acts only on strobe cycles, pulses land one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      prev_sym_r <= LS_J;
      zero_cnt_r <= 3'd0;
      ones_cnt_r <= 3'd0;
      se0_cnt_r  <= 2'd0;
      rx_active  <= 1'b0;
      rx_sop     <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 1'b0;
      rx_eop     <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      rx_sop   <= 1'b0;
      rx_valid <= 1'b0;
      rx_eop   <= 1'b0;
      rx_error <= 1'b0;
      if (strobe_s) begin
        prev_sym_r <= line_state;
        case (state_r)
          ST_IDLE: begin
            if (line_state == LS_K) begin
              state_r    <= ST_SYNC;
              zero_cnt_r <= 3'd0;
            end
          end
          ST_SYNC: begin
            if ((line_state == LS_SE0) || (line_state == LS_SE1)) begin
              state_r <= ST_IDLE;
            end else if (!bit_s) begin
              if (zero_cnt_r != 3'd7) begin
                zero_cnt_r <= zero_cnt_r + 3'd1;
              end
            end else if ({1'b0, zero_cnt_r} >= MIN_ZEROS) begin
              state_r    <= ST_DATA;
              rx_sop     <= 1'b1;
              rx_active  <= 1'b1;
              ones_cnt_r <= 3'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_DATA: begin
            if (line_state == LS_SE0) begin
              state_r   <= ST_EOP;
              se0_cnt_r <= 2'd1;
            end else if (line_state == LS_SE1) begin
              rx_error  <= 1'b1;
              rx_active <= 1'b0;
              state_r   <= ST_ABORT;
            end else if (ones_cnt_r < ONES_STUFF) begin
              rx_valid   <= 1'b1;
              rx_data    <= bit_s;
              ones_cnt_r <= bit_s ? (ones_cnt_r + 3'd1) : 3'd0;
            end else if (!bit_s) begin
              // Stuffed zero after six ones: swallow it
              ones_cnt_r <= 3'd0;
            end else begin
              rx_error  <= 1'b1;
              rx_active <= 1'b0;
              state_r   <= ST_ABORT;
            end
          end
          ST_EOP: begin
            if (line_state == LS_SE0) begin
              if (se0_cnt_r == 2'd3) begin
                rx_error  <= 1'b1;
                rx_active <= 1'b0;
                state_r   <= ST_ABORT;
              end else begin
                se0_cnt_r <= se0_cnt_r + 2'd1;
              end
            end else if (line_state == LS_J) begin
              rx_eop    <= 1'b1;
              rx_active <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              rx_error  <= 1'b1;
              rx_active <= 1'b0;
              state_r   <= ST_ABORT;
            end
          end
          ST_ABORT: begin
            if (line_state == LS_J) begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            rx_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
